// File: rtl/afe_pkg.sv
// Shared encodings for the AFE4400 result-register reader: SPI byte slots,
// result-register addresses and the read-sequencer state type.
package afe_pkg;

   localparam logic [1:0] ADDR_PART = 2'd0;
   localparam logic [1:0] H_PART    = 2'd1;
   localparam logic [1:0] M_PART    = 2'd2;
   localparam logic [1:0] L_PART    = 2'd3;

   localparam logic [7:0] LED2VAL_ADDR     = 8'h2A;
   localparam logic [7:0] ALED2VAL_ADDR    = 8'h2B;
   localparam logic [7:0] LED1VAL_ADDR     = 8'h2C;
   localparam logic [7:0] ALED1VAL_ADDR    = 8'h2D;
   localparam logic [7:0] LED2_ALED2_ADDR  = 8'h2E;
   localparam logic [7:0] LED1_ALED1_ADDR  = 8'h2F;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RDY = 2'd1,
      READ     = 2'd2,
      UPDATE   = 2'd3
   } afe_state_t;

endpackage

// File: rtl/afe_rdy_sync.sv
// Two-flop synchroniser for the AFE ADC_RDY pin plus rising-edge detector.
module afe_rdy_sync (
   input  logic div_clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise_pulse
);

   logic [2:0] sync;

   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[1:0], async_in};
   end

   // sync[1] is the first metastability-safe stage; sync[2] is its history.
   assign rise_pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/afe_data_rd.sv
// AFE4400 result reader: on each ADC_RDY edge reads N 24-bit result registers
// over SPI and publishes them atomically. Option macro: AFE_DIFF_RD_EN adds
// the two differential registers (0x2E, 0x2F).
//
// state    | meaning
// IDLE     | waiting for register initialisation to finish
// WAIT_RDY | armed, waiting for an ADC_RDY rising edge
// READ     | running read frames, assembling bytes into shadow registers
// UPDATE   | one cycle: shadow registers copied to the outputs
module afe_data_rd
   import afe_pkg::*;
#(
   parameter logic [7:0] REG_BASE = LED2VAL_ADDR,
   parameter int         RD_CNT   = 4
) (
   input  logic        div_clk,
   input  logic        rst_n,
   input  logic        ini_over,
   input  logic        adc_rdy,
   input  logic        spi_done,
   input  logic [1:0]  data_part,
   input  logic [7:0]  rx_data,
   output logic        rd_en,
   output logic [7:0]  rd_tx_data,
   output logic [23:0] led2_val,
   output logic [23:0] aled2_val,
   output logic [23:0] led1_val,
   output logic [23:0] aled1_val,
   output logic [23:0] led2_diff,
   output logic [23:0] led1_diff,
   output logic        sample_valid,
   output logic        busy,
   output logic        overrun
);

`ifdef AFE_DIFF_RD_EN
   localparam int N = RD_CNT + 2;
`else
   localparam int N = RD_CNT;
`endif
   localparam int            IW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   afe_state_t    state;
   logic [IW-1:0] idx;
   logic [23:0]   asm_word;
   logic [23:0]   shadow [N];
   logic          rdy_rise;

   afe_rdy_sync u_rdy_sync (
      .div_clk    (div_clk),
      .rst_n      (rst_n),
      .async_in   (adc_rdy),
      .rise_pulse (rdy_rise)
   );

   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         rd_en        <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         sample_valid <= 1'b0;
         rd_tx_data   <= 8'h00;
         asm_word     <= '0;
         for (int i = 0; i < N; i++) shadow[i] <= '0;
      end else begin
         sample_valid <= 1'b0;
         rd_tx_data   <= (data_part == ADDR_PART) ?
                         REG_BASE + {{(8-IW){1'b0}}, idx} : 8'h00;
         if (rdy_rise && (state == READ || state == UPDATE)) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (ini_over) state <= WAIT_RDY;
            end
            WAIT_RDY: begin
               if (!ini_over) begin
                  state <= IDLE;
               end else if (rdy_rise) begin
                  state <= READ;
                  idx   <= '0;
                  rd_en <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            READ: begin
               if (spi_done) begin
                  case (data_part)
                     H_PART: asm_word[23:16] <= rx_data;
                     M_PART: asm_word[15:8]  <= rx_data;
                     L_PART: begin
                        shadow[idx]    <= {asm_word[23:8], rx_data};
                        asm_word[7:0]  <= rx_data;
                        idx            <= idx + 1'b1;
                        if (idx == LAST) begin
                           state <= UPDATE;
                           rd_en <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            UPDATE: begin
               // idx is parked at 0 so the first address byte is ready early.
               state        <= ini_over ? WAIT_RDY : IDLE;
               idx          <= '0;
               busy         <= 1'b0;
               sample_valid <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) begin
         led2_val  <= '0;
         aled2_val <= '0;
         led1_val  <= '0;
         aled1_val <= '0;
      end else if (state == UPDATE) begin
         led2_val  <= shadow[0];
         aled2_val <= shadow[1];
         led1_val  <= shadow[2];
         aled1_val <= shadow[3];
      end
   end

`ifdef AFE_DIFF_RD_EN
   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) begin
         led2_diff <= '0;
         led1_diff <= '0;
      end else if (state == UPDATE) begin
         led2_diff <= shadow[RD_CNT];
         led1_diff <= shadow[RD_CNT+1];
      end
   end
`else
   assign led2_diff = 24'h000000;
   assign led1_diff = 24'h000000;
`endif

endmodule
